// File: rtl/mem_if_pkg.sv
// mem_if_pkg
//   Shared types and constants for the 128-bit line slow-memory interface.
//   - state_t   : transaction FSM states of line_mem_master
//   - mem_req_t : one miss request as latched by the master
//   - LINE_ADDR_W / LINE_DATA_W : line address (byte bits [31:4]) and line data widths
package mem_if_pkg;

  localparam int LINE_ADDR_W = 28;
  localparam int LINE_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    GAP  = 2'd2,
    RD   = 2'd3
  } state_t;

  typedef struct packed {
    logic                   wb;
    logic                   fill;
    logic [LINE_ADDR_W-1:0] wb_addr;
    logic [LINE_DATA_W-1:0] wb_data;
    logic [LINE_ADDR_W-1:0] fill_addr;
  } mem_req_t;

endpackage

// File: rtl/mem_stat_counters.sv
// mem_stat_counters
//   Three saturating event counters for line_mem_master activity.
//   Only instantiated when MEM_STAT_EN is defined.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset, clears all counters
//   i_rd_done    in   a memory read completed this cycle
//   i_wr_done    in   a memory write completed this cycle
//   i_busy       in   master is not IDLE this cycle
//   o_stat_rd    out  completed reads
//   o_stat_wr    out  completed writes
//   o_stat_busy  out  busy cycles
module mem_stat_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_done,
  input  logic             i_wr_done,
  input  logic             i_busy,
  output logic [CNT_W-1:0] o_stat_rd,
  output logic [CNT_W-1:0] o_stat_wr,
  output logic [CNT_W-1:0] o_stat_busy
);

  logic [CNT_W-1:0] r_rd;
  logic [CNT_W-1:0] r_wr;
  logic [CNT_W-1:0] r_busy;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_busy <= '0;
    end else begin
      if (i_rd_done) r_rd   <= sat_inc(r_rd);
      if (i_wr_done) r_wr   <= sat_inc(r_wr);
      if (i_busy)    r_busy <= sat_inc(r_busy);
    end
  end

  assign o_stat_rd   = r_rd;
  assign o_stat_wr   = r_wr;
  assign o_stat_busy = r_busy;

endmodule

// File: rtl/line_mem_master.sv
// line_mem_master
//   Cache-side initiator for the 128-bit line slow-memory protocol. Accepts one
//   miss request at a time, performs an optional victim writeback, then an
//   optional line refill, and reports completion with a one-cycle resp_valid.
//   All outputs are registered.
// Configuration macro:
//   MEM_STAT_EN - when defined, stat_rd/stat_wr/stat_busy count completed reads,
//                 completed writes and non-IDLE cycles (saturating). When
//                 undefined the stat ports are tied to zero.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (ready = idle)
//   req_wb, req_fill              writeback / refill enables
//   req_wb_addr, req_wb_data      victim line address / data
//   req_fill_addr                 refill line address
//   resp_valid, resp_data         completion pulse / last refill data
//   mem_read, mem_write           memory strobes (never both high)
//   mem_addr, mem_wdata           memory line address / write data
//   mem_rdata, mem_ready          memory read data / one-cycle completion
//   stat_rd, stat_wr, stat_busy   activity counters
module line_mem_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0] req_wb_data,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  stat_rd,
  output logic [CNT_W-1:0]  stat_wr,
  output logic [CNT_W-1:0]  stat_busy
);

  state_t            r_state;
  mem_req_t          r_req;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [LINE_W-1:0] r_resp_data;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  state_t            w_state_nxt;
  mem_req_t          w_req_nxt;
  logic              w_req_ready_nxt;
  logic              w_resp_valid_nxt;
  logic [LINE_W-1:0] w_resp_data_nxt;
  logic              w_mem_read_nxt;
  logic              w_mem_write_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [LINE_W-1:0] w_mem_wdata_nxt;

  // Next-state and next-output logic. Every registered output defaults to
  // holding its value, except the resp_valid pulse which defaults low.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_req_ready_nxt  = r_req_ready;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = r_resp_data;
    w_mem_read_nxt   = r_mem_read;
    w_mem_write_nxt  = r_mem_write;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;

    unique case (r_state)
      IDLE: begin
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        if (req_valid && r_req_ready) begin
          w_req_nxt.wb        = req_wb;
          w_req_nxt.fill      = req_fill;
          w_req_nxt.wb_addr   = LINE_ADDR_W'(req_wb_addr);
          w_req_nxt.wb_data   = LINE_DATA_W'(req_wb_data);
          w_req_nxt.fill_addr = LINE_ADDR_W'(req_fill_addr);
          if (req_wb) begin
            w_state_nxt     = WB;
            w_req_ready_nxt = 1'b0;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = req_wb_addr;
            w_mem_wdata_nxt = req_wb_data;
          end else if (req_fill) begin
            w_state_nxt     = RD;
            w_req_ready_nxt = 1'b0;
            w_mem_read_nxt  = 1'b1;
            w_mem_addr_nxt  = req_fill_addr;
          end else begin
            // Nothing to do: complete immediately and stay ready.
            w_resp_valid_nxt = 1'b1;
          end
        end
      end

      WB: begin
        // Keep presenting the latched victim until memory accepts it.
        w_mem_write_nxt = r_req.wb;
        w_mem_addr_nxt  = ADDR_W'(r_req.wb_addr);
        w_mem_wdata_nxt = LINE_W'(r_req.wb_data);
        if (mem_ready) begin
          w_mem_write_nxt = 1'b0;
          if (r_req.fill) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt      = IDLE;
            w_resp_valid_nxt = 1'b1;
            w_req_ready_nxt  = 1'b1;
          end
        end
      end

      GAP: begin
        // One dead cycle between write and read; mem_ready is not looked at.
        w_state_nxt    = RD;
        w_mem_read_nxt = 1'b1;
        w_mem_addr_nxt = ADDR_W'(r_req.fill_addr);
      end

      RD: begin
        if (mem_ready) begin
          w_state_nxt      = IDLE;
          w_mem_read_nxt   = 1'b0;
          w_resp_data_nxt  = mem_rdata;
          w_resp_valid_nxt = 1'b1;
          w_req_ready_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_req_ready_nxt = 1'b1;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  // Latched request fields are only meaningful while a transaction is open,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    r_req <= w_req_nxt;
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

`ifdef MEM_STAT_EN
  logic w_rd_done;
  logic w_wr_done;
  logic w_busy;

  assign w_rd_done = (r_state == RD) && mem_ready;
  assign w_wr_done = (r_state == WB) && mem_ready;
  assign w_busy    = (r_state != IDLE);

  mem_stat_counters #(
    .CNT_W (CNT_W)
  ) u_stat (
    .clk         (clk),
    .rst         (rst),
    .i_rd_done   (w_rd_done),
    .i_wr_done   (w_wr_done),
    .i_busy      (w_busy),
    .o_stat_rd   (stat_rd),
    .o_stat_wr   (stat_wr),
    .o_stat_busy (stat_busy)
  );
`else
  assign stat_rd   = '0;
  assign stat_wr   = '0;
  assign stat_busy = '0;
`endif

endmodule

// File: tb/tb_line_mem_master.sv
// tb_line_mem_master
//   Directed bench for line_mem_master: a transaction task plays the memory
//   side with a programmable ready delay and records what the master did.
module tb_line_mem_master;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_wb;
  logic         req_fill;
  logic [27:0]  req_wb_addr;
  logic [127:0] req_wb_data;
  logic [27:0]  req_fill_addr;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  stat_rd;
  logic [31:0]  stat_wr;
  logic [31:0]  stat_busy;

  line_mem_master #(
    .ADDR_W (28),
    .LINE_W (128),
    .CNT_W  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wb        (req_wb),
    .req_fill      (req_fill),
    .req_wb_addr   (req_wb_addr),
    .req_wb_data   (req_wb_data),
    .req_fill_addr (req_fill_addr),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .stat_rd       (stat_rd),
    .stat_wr       (stat_wr),
    .stat_busy     (stat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3 = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;
  localparam logic [127:0] W1 = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
  localparam logic [127:0] W2 = 128'h99999999_88888888_77777777_66666666;

  // Results of the last run_txn.
  int           t_wr, t_rd, t_gap, t_both, t_bad, t_resp, t_resp_at;
  logic [127:0] t_resp_data;
  logic         t_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and act as memory until resp_valid is seen (or 40 cycles).
  // Returns at the sample point of the resp_valid cycle, so a following call
  // exercises back-to-back acceptance.
  task automatic run_txn(input logic wb, input logic fill,
                         input logic [27:0] wa, input logic [127:0] wd,
                         input logic [27:0] fa, input int dw, input int dr,
                         input logic [127:0] rd, input logic spur);
    t_wr = 0; t_rd = 0; t_gap = 0; t_both = 0; t_bad = 0; t_resp = 0;
    t_resp_at = -1; t_resp_data = '0; t_ready = 1'b0;
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    req_wb_addr = wa; req_wb_data = wd; req_fill_addr = fa;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 40 && t_resp == 0; c++) begin
      mem_ready = 1'b0;
      mem_rdata = ~rd;
      if (mem_read && mem_write) t_both++;
      if (mem_write) begin
        if (mem_addr !== wa || mem_wdata !== wd) t_bad++;
        mem_ready = (t_wr == dw);
        t_wr++;
      end else if (mem_read) begin
        if (mem_addr !== fa) t_bad++;
        mem_ready = (t_rd == dr);
        if (mem_ready) mem_rdata = rd;
        t_rd++;
      end else if (resp_valid) begin
        t_resp++;
        t_resp_at   = c;
        t_resp_data = resp_data;
        t_ready     = req_ready;
      end else begin
        if (t_wr > 0 && t_rd == 0) t_gap++;
        mem_ready = spur;
      end
      if (t_resp == 0) tick();
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
    req_wb_addr = '0; req_wb_data = '0; req_fill_addr = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stat_busy", stat_busy, 0);
    tick(); tick();

    // Clean refill: ready on the 4th read cycle
    run_txn(1'b0, 1'b1, 28'h0, 128'h0, 28'h0000010, 0, 3, D1, 1'b0);
    chk("fill_rd_cycles", t_rd, 4);
    chk("fill_wr_cycles", t_wr, 0);
    chk("fill_addr_ok", t_bad, 0);
    chk("fill_resp_cnt", t_resp, 1);
    chk("fill_resp_at", t_resp_at, 4);
    chk("fill_resp_data", t_resp_data, D1);
    chk("fill_ready_at_resp", t_ready, 1);
`ifdef MEM_STAT_EN
    chk("fill_stat_rd", stat_rd, 1);
    chk("fill_stat_busy", stat_busy, 4);
`endif
    tick();
    chk("fill_resp_pulse", resp_valid, 0);
    chk("fill_addr_hold", mem_addr, 28'h0000010);

    // Dirty miss with a spurious mem_ready during GAP
    run_txn(1'b1, 1'b1, 28'h20, W1, 28'h40, 2, 1, D2, 1'b1);
    chk("dirty_wr_cycles", t_wr, 3);
    chk("dirty_gap", t_gap, 1);
    chk("dirty_rd_cycles", t_rd, 2);
    chk("dirty_addr_data_ok", t_bad, 0);
    chk("dirty_both_high", t_both, 0);
    chk("dirty_resp_cnt", t_resp, 1);
    chk("dirty_resp_at", t_resp_at, 6);
    chk("dirty_resp_data", t_resp_data, D2);

    // Writeback-only, accepted in the resp_valid cycle of the previous one
    run_txn(1'b1, 1'b0, 28'h30, W2, 28'h50, 0, 0, D3, 1'b0);
    chk("wbonly_wr_cycles", t_wr, 1);
    chk("wbonly_rd_cycles", t_rd, 0);
    chk("wbonly_resp_at", t_resp_at, 1);
    chk("wbonly_resp_data", t_resp_data, D2);

    // Null request, also back-to-back
    run_txn(1'b0, 1'b0, 28'h60, W1, 28'h70, 0, 0, D3, 1'b0);
    chk("null_traffic", t_wr + t_rd, 0);
    chk("null_resp_at", t_resp_at, 0);
    chk("null_resp_data", t_resp_data, D2);
    chk("null_ready", t_ready, 1);

    // Spurious mem_ready while idle
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_spur_read", mem_read, 0);
    chk("idle_spur_write", mem_write, 0);
    chk("idle_spur_resp", resp_valid, 0);
    chk("idle_wdata_hold", mem_wdata, W2);
    tick();

    // Reset two cycles into RD
    req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b1; req_fill_addr = 28'h55;
    tick();
    req_valid = 1'b0;
    chk("rstrd_read_up", mem_read, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrd_mem_read", mem_read, 0);
    chk("rstrd_req_ready", req_ready, 1);
    chk("rstrd_resp_valid", resp_valid, 0);
    chk("rstrd_resp_data", resp_data, 0);
    chk("rstrd_mem_addr", mem_addr, 0);
    chk("rstrd_stat_rd", stat_rd, 0);
    chk("rstrd_stat_busy", stat_busy, 0);

    // Normal operation after reset
    run_txn(1'b0, 1'b1, 28'h0, 128'h0, 28'h0000007, 0, 0, D3, 1'b0);
    chk("post_rd_cycles", t_rd, 1);
    chk("post_resp_at", t_resp_at, 1);
    chk("post_resp_data", t_resp_data, D3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_mem_master.md
Name: line_mem_master

Overview:
- Cache-side initiator for the 128-bit line slow-memory protocol (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready).
- Takes one miss request per transaction from an I- or D-cache controller.
- Performs an optional dirty-line writeback, then an optional line refill, and returns the fill data.
- Instantiated once per cache inside CHIP; drives slow_memD or slow_memI directly.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- LINE_W, 128, line data width.
- CNT_W, 32, width of statistics counters (MEM_STAT_EN only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  miss request present.
- req_ready  out  1  block idle and accepting a request.
- req_wb  in  1  perform writeback of victim line.
- req_fill  in  1  perform refill of requested line.
- req_wb_addr  in  ADDR_W  victim line address.
- req_wb_data  in  LINE_W  victim line data.
- req_fill_addr  in  ADDR_W  refill line address.
- resp_valid  out  1  one-cycle pulse, transaction complete.
- resp_data  out  LINE_W  refill data, held until next refill completes.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion, one cycle.
- stat_rd, stat_wr, stat_busy  out  CNT_W each  statistics (see Optional Feature).

Behaviour:
- All outputs registered.
- Reset values: req_ready=1, resp_valid=0, resp_data=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, state=IDLE.
- States: IDLE, WB, GAP, RD.
- IDLE: on req_valid&&req_ready, latch all req_* fields.
  - req_ready drops next cycle.
  - If req_wb: next state WB (mem_write=1, mem_addr=wb_addr, mem_wdata=wb_data).
  - Else if req_fill: next state RD (mem_read=1, mem_addr=fill_addr).
  - Else: stay in IDLE; resp_valid=1 next cycle, no memory traffic.
- WB: hold mem_write, mem_addr, mem_wdata stable until mem_ready=1 is sampled, then deassert mem_write next cycle.
  - If latched fill=1: go to GAP.
  - Else: go to IDLE with resp_valid=1 and req_ready=1; resp_data unchanged.
- GAP: exactly one cycle with mem_read=mem_write=0, then RD (mem_read=1, mem_addr=fill_addr).
- RD: hold mem_read and mem_addr until mem_ready=1 is sampled.
  - Capture mem_rdata into resp_data.
  - Next cycle: mem_read=0, resp_valid=1, req_ready=1, state=IDLE.
- Latency: with mem_ready at cycle N after the strobe rises, resp_valid (or the GAP cycle) occurs at N+1.
- mem_read and mem_write are never high together.
- mem_ready is ignored in IDLE and GAP; the cycle after a completion it is also ignored.
- req_valid is ignored while req_ready=0; no request queuing.
- resp_valid and req_ready rise together; a new request may be accepted in that same cycle.
- mem_addr and mem_wdata keep their last value when idle.
- rst mid-transaction: abandon the transaction and return every output to its reset value on the next edge; no completion is reported.

Optional Feature:
- Macro: MEM_STAT_EN.
- Defined:
  - stat_rd increments on each completed read.
  - stat_wr increments on each completed write.
  - stat_busy increments every cycle the state is not IDLE.
  - All three are saturating at all-ones and clear on rst.
- Undefined: the stat_* ports exist but are tied to 0, and no counter logic is synthesized.

Decomposition:
- Shared package mem_if_pkg holds:
  - state enum (IDLE, WB, GAP, RD);
  - LINE_ADDR_W=28 and LINE_DATA_W=128 constants;
  - a request struct {wb, fill, wb_addr, wb_data, fill_addr}.
- One natural sub-module, mem_stat_counters, containing the three saturating counters; instantiated only under MEM_STAT_EN.

Test Plan:
- Clean refill: req_fill=1, fill_addr=0x0000010, memory ready after 3 cycles with rdata=0xDEADBEEF_...:
  - mem_read high for exactly 4 cycles, mem_addr=0x0000010;
  - resp_valid 1 cycle later, resp_data=rdata.
- Dirty miss: req_wb=1, req_fill=1, wb_addr=0x20, fill_addr=0x40:
  - write phase with wdata held until ready;
  - exactly one GAP cycle with both strobes low;
  - then read at 0x40 and a single resp_valid pulse.
- Writeback-only: req_wb=1, req_fill=0:
  - single write, resp_valid pulse;
  - resp_data unchanged from its prior value.
- Null request: req_wb=0, req_fill=0:
  - resp_valid the next cycle, mem_read=mem_write=0 throughout.
- Back-to-back: a new req_valid held high during resp_valid is accepted that cycle; a spurious mem_ready pulse in IDLE or GAP is ignored.
- Reset mid-read: assert rst 2 cycles into RD:
  - next edge has mem_read=0, req_ready=1, resp_valid=0;
  - with MEM_STAT_EN, stat_rd=0 and stat_busy=0.
